viterbi_decoder: RTL and testbench
==================================

# viterbi_decoder

Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code (generators G0=111, G1=101) produced by the team's `Conv_block` encoder. It is the receive-side counterpart of that encoder. It accepts one 2-bit coded symbol per qualified cycle and collects a fixed-length frame. It then runs add-compare-select (ACS) per symbol, selects the best end state, traces back, and streams the decoded bits out serially, oldest first.

## Interface
Parameters:
- `FRAME_LEN`, default 8: decoded bits (and coded symbols) per frame, ≥ 3.
- `METRIC_W`, default 6: path-metric width; must satisfy 2^METRIC_W − 1 ≥ 2·FRAME_LEN.

Ports:
- `i_clk`  in  1  clock; all logic is on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_valid`  in  1  qualifies `i_data`; ignored while `o_busy`=1.
- `i_data`  in  2  coded symbol; bit1 = G0 output, bit0 = G1 output.
- `o_data`  out  1  decoded bit.
- `o_valid`  out  1  `o_data` is valid this cycle.
- `o_last`  out  1  high with the final decoded bit of a frame.
- `o_busy`  out  1  high while the block cannot accept symbols.

## Operation
- Encoder state is s = {s1,s0}, where s1 is the most recent input bit. Input u moves {a,b} to {u,a}.
- Expected symbol for predecessor {a,b} with input u: G0 = u^a^b, G1 = u^b.
- Branch metric is the Hamming distance (0..2) between `i_data` and the expected symbol.
- Path-metric init on entering IDLE: PM[0]=0; PM[1..3] = all-ones. All adds saturate at all-ones.
- ACS for state {u,a} on each accepted symbol:
  - Candidates are predecessors {a,0} and {a,1}.
  - Keep the smaller candidate metric. On a tie, choose b=0.
  - Write the survivor bit b into `surv[t][state]`. This memory holds FRAME_LEN×4 bits.
- FSM states:
  - IDLE/ACS: accept symbols. t counts 0..FRAME_LEN−1. Accepting symbol t=FRAME_LEN−1 moves to BEST.
  - BEST, 1 cycle: pick the state with minimum PM; on a tie, the lowest index wins.
  - TRACE, FRAME_LEN cycles: from t=FRAME_LEN−1 down to 0, `dec[t]` = state[1], then state ← {state[0], surv[t][state]}.
  - OUT, FRAME_LEN cycles: emit `dec[0]` … `dec[FRAME_LEN−1]`. Then reinit metrics and go to IDLE.
- The frame is not assumed to be terminated; the best end state is always used.
- `i_valid` while `o_busy`=1 is dropped silently; metrics and t are unchanged.
- `i_rst` at any point: the next state is IDLE, metrics are reinit, t=0, and any partial frame or pending output is discarded.

## Timing
- Reset values: `o_data`=0, `o_valid`=0, `o_last`=0, `o_busy`=0, FSM=IDLE, t=0, PM=init.
- Symbol acceptance: one symbol per cycle, no bubbles required.
- `o_busy` is registered:
  - It goes high the cycle after the final symbol of the frame is accepted.
  - It stays high through BEST, TRACE and OUT.
  - It drops the cycle after `o_last`.
- Latency: the final symbol is accepted at edge k. BEST is at k+1, TRACE covers k+2..k+FRAME_LEN+1, and the first `o_valid` is at edge k+FRAME_LEN+2.
- `o_valid` stays high for exactly FRAME_LEN consecutive cycles.
- `o_last` coincides with the FRAME_LEN-th valid bit.
- Back-to-back frames: the first symbol of the next frame can be accepted in the cycle after `o_last`.
- Outputs are registered; there is no combinational path from `i_data` to `o_data`.

## Structure
- Package `viterbi_pkg` holds:
  - localparams K=3, NUM_STATES=4, G0=3'b111, G1=3'b101;
  - the FSM state enum (IDLE, BEST, TRACE, OUT);
  - the function `branch_metric(sym, pred, u)`.
- Sub-module `viterbi_acs`: one combinational ACS unit (two metrics plus two branch metrics in; new metric and survivor bit out, saturating). It is instantiated 4× in the top.
- The survivor memory and decoded-bit buffer are flop arrays in the top.

## Test plan
- Clean frame 11 01 01 00 01 01 00 10 → `o_data` 1,1,0,1,1,0,1,0; `o_last` on the 8th bit; first `o_valid` 10 cycles after the last symbol.
- Clean frame 11 10 00 10 00 10 00 10 → 1,0,1,0,1,0,1,0.
- Clean frame 00 ×7 then 11 → 0,0,0,0,0,0,0,1.
- First frame with symbol 3 corrupted (01→11), i.e. 11 01 11 00 01 01 00 10 → still 1,1,0,1,1,0,1,0.
- Send 4 symbols, assert `i_rst` for 1 cycle, then send the 10101010 frame → exactly 8 valid bits, 1,0,1,0,1,0,1,0; nothing emitted from the aborted frame.
- Hold `i_valid`=1 with garbage data throughout BEST/TRACE/OUT of the first frame, then send the second frame right after `o_last` → garbage is ignored and the second frame decodes correctly.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3, rate-1/2 (G0=111, G1=101) hard-decision Viterbi decoder.
package viterbi_pkg;

    localparam int         K          = 3;
    localparam int         NUM_STATES = 4;
    localparam logic [2:0] G0         = 3'b111;
    localparam logic [2:0] G1         = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        BEST,
        TRACE,
        OUT
    } state_e;

    // Hamming distance between the received symbol and the symbol the encoder
    // emits when input u arrives in predecessor state pred = {a,b}.
    function automatic logic [1:0] branch_metric(input logic [1:0] sym,
                                                 input logic [1:0] pred,
                                                 input logic       u);
        logic [2:0] w_reg;
        logic       w_g0;
        logic       w_g1;
        w_reg = {u, pred};
        w_g0  = ^(w_reg & G0);
        w_g1  = ^(w_reg & G1);
        return {1'b0, sym[1] ^ w_g0} + {1'b0, sym[0] ^ w_g1};
    endfunction

endpackage

// File: rtl/viterbi_decoder_if.sv
// Symbol-in / bit-out handshake bundle of the Viterbi decoder.
interface viterbi_decoder_if;

    logic       i_valid;
    logic [1:0] i_data;
    logic       o_data;
    logic       o_valid;
    logic       o_last;
    logic       o_busy;

    modport master (
        output i_valid, i_data,
        input  o_data, o_valid, o_last, o_busy
    );

    modport slave (
        input  i_valid, i_data,
        output o_data, o_valid, o_last, o_busy
    );

endinterface

// File: rtl/viterbi_acs.sv
// Combinational add-compare-select for one trellis state; ties favour the b=0 predecessor.
module viterbi_acs #(
    parameter int METRIC_W = 6
) (
    input  logic [METRIC_W-1:0] i_pm0,
    input  logic [METRIC_W-1:0] i_pm1,
    input  logic [1:0]          i_bm0,
    input  logic [1:0]          i_bm1,
    output logic [METRIC_W-1:0] o_pm,
    output logic                o_surv
);

    function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] pm,
                                                    input logic [1:0]          bm);
        logic [METRIC_W:0] w_sum;
        w_sum = {1'b0, pm} + {{(METRIC_W-1){1'b0}}, bm};
        return w_sum[METRIC_W] ? '1 : w_sum[METRIC_W-1:0];
    endfunction

    logic [METRIC_W-1:0] w_c0;
    logic [METRIC_W-1:0] w_c1;

    assign w_c0   = sat_add(i_pm0, i_bm0);
    assign w_c1   = sat_add(i_pm1, i_bm1);
    assign o_surv = (w_c1 < w_c0);
    assign o_pm   = o_surv ? w_c1 : w_c0;

endmodule

// File: rtl/viterbi_decoder.sv
// Frame-based hard-decision Viterbi decoder: ACS per symbol, best-state pick,
// traceback through a flop survivor memory, then serial oldest-first output.
module viterbi_decoder
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int METRIC_W  = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    viterbi_decoder_if.slave  io_bus
);

    localparam int             T_W    = $clog2(FRAME_LEN);
    localparam logic [T_W-1:0] T_LAST = T_W'(FRAME_LEN - 1);

    state_e                  r_state;
    state_e                  w_next;
    logic [T_W-1:0]          r_t;
    logic [METRIC_W-1:0]     r_pm   [NUM_STATES];
    logic [METRIC_W-1:0]     w_pm   [NUM_STATES];
    logic [NUM_STATES-1:0]   w_surv;
    logic [NUM_STATES-1:0]   r_surv [FRAME_LEN];
    logic [FRAME_LEN-1:0]    r_dec;
    logic [1:0]              r_tb;
    logic [1:0]              w_best;
    logic [METRIC_W-1:0]     w_min;
    logic                    w_accept;
    logic                    r_busy;
    logic                    r_data;
    logic                    r_valid;
    logic                    r_last;

    assign w_accept = (r_state == IDLE) && io_bus.i_valid && !r_busy;

    // State {u,a} is reached from predecessors {a,0} and {a,1} with input u.
    for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
        localparam int U = s / 2;
        localparam int A = s % 2;
        logic [1:0] w_bm0;
        logic [1:0] w_bm1;
        assign w_bm0 = branch_metric(io_bus.i_data, 2'(2 * A),     1'(U));
        assign w_bm1 = branch_metric(io_bus.i_data, 2'(2 * A + 1), 1'(U));
        viterbi_acs #(.METRIC_W(METRIC_W)) u_acs (
            .i_pm0  (r_pm[2 * A]),
            .i_pm1  (r_pm[2 * A + 1]),
            .i_bm0  (w_bm0),
            .i_bm1  (w_bm1),
            .o_pm   (w_pm[s]),
            .o_surv (w_surv[s])
        );
    end

    always_comb begin
        w_best = 2'd0;
        w_min  = r_pm[0];
        for (int s = 1; s < NUM_STATES; s++) begin
            if (r_pm[s] < w_min) begin
                w_min  = r_pm[s];
                w_best = 2'(s);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && r_t == T_LAST) w_next = BEST;
            BEST:    w_next = TRACE;
            TRACE:   if (r_t == '0) w_next = OUT;
            OUT:     if (r_t == T_LAST) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_t     <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= 1'b0;
            for (int s = 0; s < NUM_STATES; s++) r_pm[s] <= (s == 0) ? '0 : '1;
        end else begin
            // Busy is held one extra cycle past OUT so it falls after o_last.
            r_busy  <= (w_next != IDLE) || (r_state == OUT);
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        for (int s = 0; s < NUM_STATES; s++) r_pm[s] <= w_pm[s];
                        r_surv[r_t] <= w_surv;
                        if (r_t != T_LAST) r_t <= r_t + T_W'(1);
                    end
                end
                BEST: begin
                    r_tb <= w_best;
                end
                TRACE: begin
                    r_dec[r_t] <= r_tb[1];
                    r_tb       <= {r_tb[0], r_surv[r_t][r_tb]};
                    if (r_t != '0) r_t <= r_t - T_W'(1);
                end
                OUT: begin
                    r_valid <= 1'b1;
                    r_data  <= r_dec[r_t];
                    r_last  <= (r_t == T_LAST);
                    if (r_t == T_LAST) begin
                        r_t <= '0;
                        for (int s = 0; s < NUM_STATES; s++) r_pm[s] <= (s == 0) ? '0 : '1;
                    end else begin
                        r_t <= r_t + T_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.o_data  = r_data;
    assign io_bus.o_valid = r_valid;
    assign io_bus.o_last  = r_last;
    assign io_bus.o_busy  = r_busy;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboard bench for viterbi_decoder: directed frames push expected bits, a monitor pops them.
module tb_viterbi_decoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    viterbi_decoder_if u_if ();

    viterbi_decoder #(.FRAME_LEN(8), .METRIC_W(6)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (u_if.slave)
    );

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         last_acc = 0;
    logic [1:0] exp_q[$];
    bit         first_of_frame = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented output bit is compared against the head of the queue.
    always @(negedge clk) begin
        logic [1:0] e;
        if (u_if.o_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got data=%0d last=%0d expected no output (cycle %0d)",
                         u_if.o_data, u_if.o_last, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", int'(u_if.o_data), int'(e[1]));
                chk("out_last", int'(u_if.o_last), int'(e[0]));
                if (first_of_frame) chk("first_valid_latency", cyc - last_acc, 10);
                first_of_frame = u_if.o_last;
            end
        end
    end

    task automatic send_sym(input logic [1:0] s, output int waited);
        waited = 0;
        @(negedge clk);
        while (u_if.o_busy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (u_if.o_busy) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout: got busy=1 expected busy=0 within 200 cycles");
        end
        u_if.i_valid = 1'b1;
        u_if.i_data  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] syms, input logic [7:0] bits, output int first_wait);
        int w;
        for (int i = 0; i < 8; i++) exp_q.push_back({bits[7-i], (i == 7) ? 1'b1 : 1'b0});
        for (int i = 0; i < 8; i++) begin
            send_sym(syms[15-2*i -: 2], w);
            if (i == 0) first_wait = w;
        end
        last_acc = cyc;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clk);
        u_if.i_valid = 1'b0;
        while ((exp_q.size() != 0 || u_if.o_busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        int w;
        int n;
        rst          = 1'b1;
        u_if.i_valid = 1'b0;
        u_if.i_data  = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_o_valid", int'(u_if.o_valid), 0);
        chk("rst_o_last",  int'(u_if.o_last),  0);
        chk("rst_o_busy",  int'(u_if.o_busy),  0);
        chk("rst_o_data",  int'(u_if.o_data),  0);
        rst = 1'b0;

        send_frame(16'hD452, 8'hDA, w);
        @(negedge clk);
        u_if.i_valid = 1'b0;
        chk("busy_after_last_sym", int'(u_if.o_busy), 1);
        wait_done("frame_clean1_done");

        send_frame(16'hE222, 8'hAA, w);
        wait_done("frame_alt_done");

        send_frame(16'h0003, 8'h01, w);
        wait_done("frame_zeros_done");

        send_frame(16'hDC52, 8'hDA, w);
        wait_done("frame_corrupt_done");

        // Abort a partial frame with reset; nothing from it may ever appear.
        send_sym(2'b11, w);
        send_sym(2'b01, w);
        send_sym(2'b01, w);
        send_sym(2'b00, w);
        @(negedge clk);
        u_if.i_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(u_if.o_busy), 0);
        send_frame(16'hE222, 8'hAA, w);
        wait_done("frame_after_rst_done");

        // Garbage held on the input while the decoder is busy must be ignored.
        send_frame(16'hD452, 8'hDA, w);
        n = 0;
        @(negedge clk);
        while (u_if.o_last !== 1'b1 && n < 100) begin
            u_if.i_valid = 1'b1;
            u_if.i_data  = 2'($urandom_range(0, 3));
            @(negedge clk);
            n++;
        end
        chk("garbage_saw_last", int'(u_if.o_last), 1);
        chk("busy_at_last", int'(u_if.o_busy), 1);
        send_frame(16'hE222, 8'hAA, w);
        chk("back_to_back_wait", w, 0);
        wait_done("frame_b2b_done");

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
